// File: rtl/norm_shift_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : norm_shift_unit_pkg
//  Description : Shared FSM state encoding, mode count limits and stage-count
//                helper for the normaliser (norm_shift_unit) and its step.
//  Revision    : 1.0 - initial release
// ============================================================================
package norm_shift_unit_pkg;

    // Default operand width and matching count width.
    localparam int c_DEF_WIDTH = 32;
    localparam int c_DEF_CNT_W = $clog2(c_DEF_WIDTH) + 1;

    // FSM state encoding (explicit width, legacy-compatible constants).
    typedef logic [1:0] state_t;
    localparam state_t c_ST_IDLE = 2'd0;
    localparam state_t c_ST_RUN  = 2'd1;
    localparam state_t c_ST_FIN  = 2'd2;

    // Largest shift count in leading-zero mode: an all-zero operand shifts WIDTH.
    function automatic int f_max_lz(input int width);
        return width;
    endfunction

    // Largest shift count in sign mode: the sign bit itself is never redundant.
    function automatic int f_max_ls(input int width);
        return width - 1;
    endfunction

    // Number of binary-search stages needed to cover WIDTH-1 shifts.
    function automatic int f_stage_cnt(input int width);
        return $clog2(width);
    endfunction

endpackage : norm_shift_unit_pkg
`default_nettype wire

// File: rtl/norm_shift_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : norm_shift_unit_if
//  Description : Start/done request bus between the core and the normaliser.
//                master = requester (core), slave = normaliser.
//  Revision    : 1.0 - initial release
// ============================================================================
interface norm_shift_unit_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
);
    logic             start;
    logic [WIDTH-1:0] data_in;
    logic             sign_mode;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] norm_out;
    logic [CNT_W-1:0] sa_out;
    logic             zero_out;

    modport master (
        output start, data_in, sign_mode,
        input  busy, done, norm_out, sa_out, zero_out
    );

    modport slave (
        input  start, data_in, sign_mode,
        output busy, done, norm_out, sa_out, zero_out
    );
endinterface : norm_shift_unit_if
`default_nettype wire

// File: rtl/norm_shift_unit_norm_step.sv
`default_nettype none
// ============================================================================
//  Module      : norm_step
//  Description : Combinational test-and-shift. Shifts the work word left by
//                i_s when the top i_s bits are zero (leading-zero mode) or the
//                top i_s+1 bits are all equal (sign mode).
//  Revision    : 1.0 - initial release
// ============================================================================
module norm_step
    import norm_shift_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  wire logic [WIDTH-1:0] i_w,
    input  wire logic [CNT_W-1:0] i_s,
    input  wire logic             i_sign_mode,
    output logic      [WIDTH-1:0] o_w,
    output logic                  o_shifted
);
    localparam logic [WIDTH-1:0] c_ONES = '1;
    localparam logic [CNT_W:0]   c_ONE  = (CNT_W+1)'(1);

    logic [CNT_W:0]   w_s_plus1;
    logic [WIDTH-1:0] w_mask_s;
    logic [WIDTH-1:0] w_mask_s1;
    logic [WIDTH-1:0] w_top_s1;

    // Masks selecting the top s and top s+1 bits; decide whether to shift.
    always_comb begin
        w_s_plus1 = {1'b0, i_s} + c_ONE;
        w_mask_s  = ~(c_ONES >> i_s);
        w_mask_s1 = ~(c_ONES >> w_s_plus1);
        w_top_s1  = i_w & w_mask_s1;
        if (i_sign_mode) begin
            o_shifted = (w_top_s1 == '0) || (w_top_s1 == w_mask_s1);
        end else begin
            o_shifted = ((i_w & w_mask_s) == '0);
        end
        o_w = o_shifted ? (i_w << i_s) : i_w;
    end

endmodule : norm_step
`default_nettype wire

// File: rtl/norm_shift_unit.sv
`default_nettype none
// ============================================================================
//  Module      : norm_shift_unit
//  Description : Multi-cycle normaliser (CLZ / CLS). Returns the left-justified
//                operand and the shift amount so norm_out == data_in << sa_out.
//                Build option NORM_SHIFT_FAST_EN: binary search, fixed latency
//                of log2(WIDTH)+2; otherwise serial one-bit-per-cycle search.
//  Revision    : 1.0 - initial release
// ============================================================================
module norm_shift_unit
    import norm_shift_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    norm_shift_unit_if.slave bus
);
    localparam logic [CNT_W-1:0] c_MAX_LZ = CNT_W'(f_max_lz(WIDTH));
    localparam logic [CNT_W-1:0] c_MAX_LS = CNT_W'(f_max_ls(WIDTH));
    localparam logic [CNT_W-1:0] c_ONE    = CNT_W'(1);

    state_t           r_state;
    logic [WIDTH-1:0] r_work;
    logic             r_mode;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_norm;
    logic [CNT_W-1:0] r_sa;
    logic             r_zero;
    logic             r_done;

    logic [CNT_W-1:0] w_s;
    logic [WIDTH-1:0] w_step_w;
    logic             w_shifted;
    logic [CNT_W-1:0] w_max;

`ifdef NORM_SHIFT_FAST_EN
    localparam logic [CNT_W-1:0] c_FIRST_STEP = CNT_W'(1 << (f_stage_cnt(WIDTH) - 1));

    // Current binary-search step size; zero marks the final fix-up cycle.
    logic [CNT_W-1:0] r_step;
    logic             w_take;
    assign w_s    = r_step;
    // Never let a step push the count past the mode's limit.
    assign w_take = w_shifted &&
                    (({1'b0, r_cnt} + {1'b0, r_step}) <= {1'b0, w_max});
`else
    logic w_stop;
    assign w_s    = c_ONE;
    assign w_stop = !w_shifted || (r_cnt == w_max);
`endif

    assign w_max = r_mode ? c_MAX_LS : c_MAX_LZ;

    norm_step #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_norm_step (
        .i_w         (r_work),
        .i_s         (w_s),
        .i_sign_mode (r_mode),
        .o_w         (w_step_w),
        .o_shifted   (w_shifted)
    );

    // Job sequencing: accept in IDLE, search in RUN, publish results in FIN.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
            r_work  <= '0;
            r_mode  <= 1'b0;
            r_cnt   <= '0;
            r_norm  <= '0;
            r_sa    <= '0;
            r_zero  <= 1'b0;
            r_done  <= 1'b0;
`ifdef NORM_SHIFT_FAST_EN
            r_step  <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.start) begin
                        r_work  <= bus.data_in;
                        r_mode  <= bus.sign_mode;
                        r_cnt   <= '0;
`ifdef NORM_SHIFT_FAST_EN
                        r_step  <= c_FIRST_STEP;
`endif
                        r_state <= c_ST_RUN;
                    end
                end
                c_ST_RUN: begin
`ifdef NORM_SHIFT_FAST_EN
                    if (r_step != '0) begin
                        if (w_take) begin
                            r_work <= w_step_w;
                            r_cnt  <= r_cnt + r_step;
                        end
                        r_step <= r_step >> 1;
                    end else begin
                        // After the search an all-zero word still needs one
                        // more count to reach WIDTH in leading-zero mode.
                        if (!r_mode && !r_work[WIDTH-1]) begin
                            r_cnt <= r_cnt + c_ONE;
                        end
                        r_state <= c_ST_FIN;
                    end
`else
                    if (w_stop) begin
                        r_state <= c_ST_FIN;
                    end else begin
                        r_work <= w_step_w;
                        r_cnt  <= r_cnt + c_ONE;
                    end
`endif
                end
                c_ST_FIN: begin
                    r_norm  <= r_work;
                    r_sa    <= r_cnt;
                    r_zero  <= (r_cnt == w_max);
                    r_done  <= 1'b1;
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = (r_state != c_ST_IDLE);
    assign bus.done     = r_done;
    assign bus.norm_out = r_norm;
    assign bus.sa_out   = r_sa;
    assign bus.zero_out = r_zero;

endmodule : norm_shift_unit
`default_nettype wire

// File: tb/tb_norm_shift_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_norm_shift_unit
//  Description : Self-checking bench for norm_shift_unit (WIDTH=32): directed
//                vector table, handshake/reset sequences, random operands.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_norm_shift_unit;
    localparam int WIDTH = 32;
    localparam int CNT_W = 6;
    localparam int BUDGET = 100;

    typedef struct {
        logic [31:0] data;
        logic        mode;
        logic [31:0] exp_norm;
        int          exp_sa;
        logic        exp_zero;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    norm_shift_unit_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    norm_shift_unit #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input int sa);
`ifdef NORM_SHIFT_FAST_EN
        return $clog2(WIDTH) + 2;
`else
        return sa + 2;
`endif
    endfunction

    // Independent reference: scan for the first bit that ends the run.
    task automatic model(input logic [31:0] d, input logic m,
                         output logic [31:0] n, output int sa, output logic z);
        if (!m) begin
            sa = 32;
            for (int i = 31; i >= 0; i--) begin
                if (d[i]) begin sa = 31 - i; break; end
            end
        end else begin
            sa = 31;
            for (int i = 30; i >= 0; i--) begin
                if (d[i] != d[31]) begin sa = 30 - i; break; end
            end
        end
        n = (sa >= 32) ? 32'h0 : (d << sa);
        z = m ? (sa == 31) : (sa == 32);
    endtask

    // Issue one start, return edges from accept to done and busy after accept.
    task automatic run_job(input logic [31:0] d, input logic m,
                           output int lat, output logic ok, output logic busy1);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.data_in   = d;
        bus.sign_mode = m;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        busy1     = bus.busy;
        lat = 0;
        ok  = 1'b0;
        for (int k = 0; k < BUDGET; k++) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.done) begin ok = 1'b1; break; end
        end
    endtask

    vec_t vecs [13];

    initial begin
        int          lat;
        int          msa;
        int          gap;
        int          ndone;
        logic        ok;
        logic        b1;
        logic        mz;
        logic [31:0] mn;
        logic [31:0] d;
        logic        m;

        n_cmp = 0;
        n_err = 0;
        vecs[0]  = '{32'h0000_1234, 1'b0, 32'h91A0_0000, 19, 1'b0};
        vecs[1]  = '{32'h8000_0000, 1'b0, 32'h8000_0000,  0, 1'b0};
        vecs[2]  = '{32'h0000_0000, 1'b0, 32'h0000_0000, 32, 1'b1};
        vecs[3]  = '{32'h0000_0000, 1'b1, 32'h0000_0000, 31, 1'b1};
        vecs[4]  = '{32'hFFFF_F000, 1'b1, 32'h8000_0000, 19, 1'b0};
        vecs[5]  = '{32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 31, 1'b1};
        vecs[6]  = '{32'h0000_0001, 1'b0, 32'h8000_0000, 31, 1'b0};
        vecs[7]  = '{32'h0000_0001, 1'b1, 32'h4000_0000, 30, 1'b0};
        vecs[8]  = '{32'h7FFF_FFFF, 1'b1, 32'h7FFF_FFFF,  0, 1'b0};
        vecs[9]  = '{32'h4000_0000, 1'b0, 32'h8000_0000,  1, 1'b0};
        vecs[10] = '{32'h0000_FFFF, 1'b1, 32'h7FFF_8000, 15, 1'b0};
        vecs[11] = '{32'hC000_0000, 1'b1, 32'h8000_0000,  1, 1'b0};
        vecs[12] = '{32'h8000_0000, 1'b1, 32'h8000_0000,  0, 1'b0};

        bus.start     = 1'b0;
        bus.data_in   = '0;
        bus.sign_mode = 1'b0;
        rst_n         = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_done", 64'(bus.done), 64'd0);
        chk("reset_norm", 64'(bus.norm_out), 64'd0);
        chk("reset_sa",   64'(bus.sa_out), 64'd0);
        chk("reset_zero", 64'(bus.zero_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table.
        for (int i = 0; i < 13; i++) begin
            run_job(vecs[i].data, vecs[i].mode, lat, ok, b1);
            chk($sformatf("v%0d_timeout", i), 64'(ok), 64'd1);
            chk($sformatf("v%0d_busy", i), 64'(b1), 64'd1);
            chk($sformatf("v%0d_norm", i), 64'(bus.norm_out), 64'(vecs[i].exp_norm));
            chk($sformatf("v%0d_sa", i), 64'(bus.sa_out), 64'(vecs[i].exp_sa));
            chk($sformatf("v%0d_zero", i), 64'(bus.zero_out), 64'(vecs[i].exp_zero));
            chk($sformatf("v%0d_lat", i), 64'(lat), 64'(exp_lat(vecs[i].exp_sa)));
        end

        // Outputs hold between jobs, done is a single pulse, busy drops.
        repeat (3) @(posedge clk);
        #1;
        chk("hold_norm", 64'(bus.norm_out), 64'h8000_0000);
        chk("hold_done", 64'(bus.done), 64'd0);
        chk("hold_busy", 64'(bus.busy), 64'd0);

        // start held every cycle while busy, with a changing operand.
        @(negedge clk);
        bus.start     = 1'b1;
        bus.data_in   = 32'h0000_1234;
        bus.sign_mode = 1'b0;
        @(posedge clk);
        #1;
        lat   = 0;
        ndone = 0;
        for (int k = 0; k < BUDGET; k++) begin
            bus.data_in   = 32'hFFFF_FFFF;
            bus.sign_mode = k[0];
            @(posedge clk);
            #1;
            lat++;
            if (bus.done) begin ndone++; break; end
        end
        bus.start = 1'b0;
        chk("hold_start_done", 64'(ndone), 64'd1);
        chk("hold_start_lat", 64'(lat), 64'(exp_lat(19)));
        chk("hold_start_norm", 64'(bus.norm_out), 64'h91A0_0000);
        chk("hold_start_sa", 64'(bus.sa_out), 64'd19);
        repeat (30) begin
            @(posedge clk);
            #1;
            if (bus.done) ndone++;
        end
        chk("hold_start_extra", 64'(ndone), 64'd1);

        // Back-to-back: start asserted through the done cycle.
        @(negedge clk);
        bus.start     = 1'b1;
        bus.data_in   = 32'h8000_0000;
        bus.sign_mode = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < BUDGET; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin ok = 1'b1; break; end
        end
        chk("b2b_first", 64'(ok), 64'd1);
        gap = 0;
        ok  = 1'b0;
        for (int k = 0; k < BUDGET; k++) begin
            @(posedge clk);
            #1;
            gap++;
            if (bus.done) begin ok = 1'b1; break; end
        end
        bus.start = 1'b0;
        chk("b2b_second", 64'(ok), 64'd1);
        chk("b2b_gap", 64'(gap), 64'(exp_lat(0) + 1));

        // Reset in the middle of a long job: no done, outputs cleared.
        @(negedge clk);
        bus.start     = 1'b1;
        bus.data_in   = 32'h0000_0000;
        bus.sign_mode = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_busy", 64'(bus.busy), 64'd0);
        chk("rst_mid_done", 64'(bus.done), 64'd0);
        chk("rst_mid_norm", 64'(bus.norm_out), 64'd0);
        chk("rst_mid_sa", 64'(bus.sa_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (45) begin
            @(posedge clk);
            #1;
            if (bus.done) ndone++;
        end
        chk("rst_mid_nodone", 64'(ndone), 64'd0);

        // Random operands against the reference scan.
        for (int i = 0; i < 200; i++) begin
            d = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 3) == 0) d = 32'h0;
            m = 1'($urandom_range(0, 1));
            if (m && $urandom_range(0, 1) == 1) d = ~d;
            model(d, m, mn, msa, mz);
            run_job(d, m, lat, ok, b1);
            chk($sformatf("r%0d_timeout", i), 64'(ok), 64'd1);
            chk($sformatf("r%0d_norm", i), 64'(bus.norm_out), 64'(mn));
            chk($sformatf("r%0d_sa", i), 64'(bus.sa_out), 64'(msa));
            chk($sformatf("r%0d_zero", i), 64'(bus.zero_out), 64'(mz));
            chk($sformatf("r%0d_lat", i), 64'(lat), 64'(exp_lat(msa)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_norm_shift_unit
`default_nettype wire
